// File: rtl/psu_counter_checker.sv
// Self-test driver for the PSU ripple-counter macro: generates its clock and reset,
// synchronises its 4-bit count back into clk and tallies mismatches against an expected count.
module psu_counter_checker #(
    parameter int HALF_PERIOD  = 8,
    parameter int SETTLE       = 4,
    parameter int NUM_EDGES    = 32,
    parameter int RESET_CYCLES = 4,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [3:0]       macro_count,
    output logic             macro_clk,
    output logic             macro_n_reset,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       observed
);
    // state  | meaning
    // IDLE   | macro held in reset, waiting for start
    // RESET  | macro_n_reset low for RESET_CYCLES cycles
    // CHECK0 | macro out of reset, settle then compare against 0
    // RUN    | toggle macro_clk, compare SETTLE+2 cycles after each rising edge
    // DONE   | result held, macro idle out of reset, waiting for start

    localparam int TW = 16;
    localparam logic [TW-1:0] PERIOD_LAST = TW'(2 * HALF_PERIOD - 1);
    localparam logic [TW-1:0] FALL_T      = TW'(HALF_PERIOD);
    localparam logic [TW-1:0] CMP_T       = TW'(2 * HALF_PERIOD - SETTLE - 3);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    if (SETTLE + 2 >= 2 * HALF_PERIOD) begin : g_settle_check
        $error("SETTLE+2 must be less than 2*HALF_PERIOD");
    end

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_CHECK0, S_RUN, S_DONE} state_t;

    state_t           state, state_d;
    logic [TW-1:0]    timer, timer_d;
    logic [TW-1:0]    edge_cnt, edge_cnt_d;
    logic [3:0]       expected, expected_d;
    logic [3:0]       sync1, sync2;
    logic             macro_clk_d, macro_n_reset_d, busy_d, done_d, pass_d;
    logic [ERR_W-1:0] err_count_d;
    logic [3:0]       observed_d;
    logic             sample;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= macro_count;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_d         = state;
        timer_d         = timer;
        edge_cnt_d      = edge_cnt;
        expected_d      = expected;
        macro_clk_d     = macro_clk;
        macro_n_reset_d = macro_n_reset;
        err_count_d     = err_count;
        observed_d      = observed;
        done_d          = done;
        sample          = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                macro_clk_d = 1'b0;
                if (start) begin
                    state_d         = S_RESET;
                    timer_d         = TW'(RESET_CYCLES - 1);
                    expected_d      = '0;
                    edge_cnt_d      = '0;
                    err_count_d     = '0;
                    done_d          = 1'b0;
                    macro_n_reset_d = 1'b0;
                end
            end
            S_RESET: begin
                if (timer == '0) begin
                    state_d         = S_CHECK0;
                    timer_d         = TW'(SETTLE + 1);
                    macro_n_reset_d = 1'b1;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            S_CHECK0: begin
                if (timer == '0) begin
                    sample      = 1'b1;
                    state_d     = S_RUN;
                    timer_d     = PERIOD_LAST;
                    macro_clk_d = 1'b1;
                    expected_d  = expected + 4'd1;
                    edge_cnt_d  = edge_cnt + 1'b1;
                end else begin
                    timer_d = timer - 1'b1;
                end
            end
            S_RUN: begin
                timer_d = timer - 1'b1;
                if (timer == CMP_T) sample = 1'b1;
                if (timer == FALL_T) macro_clk_d = 1'b0;
                if (timer == '0) begin
                    if (edge_cnt == TW'(NUM_EDGES)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        timer_d     = PERIOD_LAST;
                        macro_clk_d = 1'b1;
                        expected_d  = expected + 4'd1;
                        edge_cnt_d  = edge_cnt + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // expected is read before its own update, so CHECK0 compares against 0
        if (sample) begin
            observed_d = sync2;
            if (sync2 != expected && err_count != ERR_MAX) err_count_d = err_count + ERR_W'(1);
        end

        busy_d = (state_d == S_RESET) || (state_d == S_CHECK0) || (state_d == S_RUN);
        pass_d = (state_d == S_DONE) && (err_count_d == '0);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            edge_cnt      <= '0;
            expected      <= '0;
            macro_clk     <= 1'b0;
            macro_n_reset <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            observed      <= '0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            edge_cnt      <= edge_cnt_d;
            expected      <= expected_d;
            macro_clk     <= macro_clk_d;
            macro_n_reset <= macro_n_reset_d;
            busy          <= busy_d;
            done          <= done_d;
            pass          <= pass_d;
            err_count     <= err_count_d;
            observed      <= observed_d;
        end
    end
endmodule

// File: tb/tb_psu_counter_checker.sv
// Directed bench for psu_counter_checker: behavioural macro models (ideal, stuck bit,
// late update, constant) against hand-computed error counts, latency and reset behaviour.
module tb_psu_counter_checker;
    localparam int LAT = 523;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       start = 1'b0;
    logic       start_sat = 1'b0;
    logic [3:0] macro_count;
    logic       macro_clk, macro_n_reset, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] observed;
    logic       macro_clk_sat, macro_n_reset_sat, busy_sat, done_sat, pass_sat;
    logic [3:0] err_count_sat;
    logic [3:0] observed_sat;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;

    logic [3:0] cnt = 4'd0;
    logic       mclk_prev = 1'b0;
    logic [3:0] pipe [6];
    int         edges_seen = 0;
    int         hist [16];
    logic [7:0] err_prev = 8'd0;

    always #5 clk = ~clk;

    psu_counter_checker u_dut (
        .clk(clk), .n_reset(n_reset), .start(start), .macro_count(macro_count),
        .macro_clk(macro_clk), .macro_n_reset(macro_n_reset), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .observed(observed)
    );

    psu_counter_checker #(.ERR_W(4)) u_sat (
        .clk(clk), .n_reset(n_reset), .start(start_sat), .macro_count(4'hF),
        .macro_clk(macro_clk_sat), .macro_n_reset(macro_n_reset_sat), .busy(busy_sat),
        .done(done_sat), .pass(pass_sat), .err_count(err_count_sat), .observed(observed_sat)
    );

    // mode 0 ideal, 1 bit2 stuck at 0, 2 update lands 7 cycles after the rising edge
    always_comb begin
        case (mode)
            1:       macro_count = cnt & 4'b1011;
            2:       macro_count = pipe[5];
            default: macro_count = cnt;
        endcase
    end

    always @(posedge clk) begin
        mclk_prev <= macro_clk;
        err_prev  <= err_count;
        if (!macro_n_reset) begin
            cnt        <= 4'd0;
            edges_seen <= 0;
            for (int i = 0; i < 16; i++) hist[i] <= 0;
            for (int i = 0; i < 6; i++) pipe[i] <= 4'd0;
        end else begin
            if (macro_clk && !mclk_prev) begin
                cnt        <= cnt + 4'd1;
                edges_seen <= edges_seen + 1;
            end
            if (err_count != err_prev) hist[edges_seen & 15] <= hist[edges_seen & 15] + 1;
            pipe[0] <= cnt;
            for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic run_main(input int restart_at, output int cyc);
        cyc = 0;
        start = 1'b1;
        while (cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_after_start got %b want 1", busy);
                end
            end
            if (done === 1'b1) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 n_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({macro_clk, macro_n_reset, busy, done, pass} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000", {macro_clk, macro_n_reset, busy, done, pass});
        end
        vectors++;
        if (err_count !== 8'd0 || observed !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_counts got err=%0d obs=%0d want 0 0", err_count, observed);
        end
        n_reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || macro_n_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset got busy=%b mnr=%b want 0 0", busy, macro_n_reset);
        end
    endtask

    task automatic test_ideal();
        int lat;
        mode = 0;
        run_main(-1, lat);
        vectors++;
        if (lat !== LAT) begin miscompares++; $display("FAIL ideal_latency got %0d want %0d", lat, LAT); end
        vectors++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL ideal_result got pass=%b err=%0d want 1 0", pass, err_count);
        end
        vectors++;
        if (observed !== 4'd0) begin miscompares++; $display("FAIL ideal_observed got %0d want 0", observed); end
        vectors++;
        if (edges_seen !== 32) begin miscompares++; $display("FAIL ideal_edges got %0d want 32", edges_seen); end
        vectors++;
        if (macro_clk !== 1'b0 || busy !== 1'b0 || macro_n_reset !== 1'b1) begin
            miscompares++;
            $display("FAIL ideal_end got mclk=%b busy=%b mnr=%b want 0 0 1", macro_clk, busy, macro_n_reset);
        end
    endtask

    task automatic test_start_mid_run();
        int lat;
        mode = 0;
        run_main(200, lat);
        vectors++;
        if (lat !== LAT) begin miscompares++; $display("FAIL midstart_latency got %0d want %0d", lat, LAT); end
        vectors++;
        if (pass !== 1'b1 || edges_seen !== 32) begin
            miscompares++;
            $display("FAIL midstart_result got pass=%b edges=%0d want 1 32", pass, edges_seen);
        end
    endtask

    task automatic test_stuck();
        int lat;
        mode = 1;
        run_main(-1, lat);
        vectors++;
        if (err_count !== 8'd16 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_result got err=%0d pass=%b want 16 0", err_count, pass);
        end
        for (int v = 0; v < 16; v++) begin
            int want;
            want = ((v & 4) != 0) ? 2 : 0;
            vectors++;
            if (hist[v] !== want) begin
                miscompares++;
                $display("FAIL stuck_hist_%0d got %0d want %0d", v, hist[v], want);
            end
        end
    endtask

    task automatic test_restart();
        int low_cnt;
        int cyc;
        mode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || err_count !== 8'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_clear got done=%b err=%0d busy=%b want 0 0 1", done, err_count, busy);
        end
        low_cnt = (macro_n_reset === 1'b0) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (macro_n_reset !== 1'b0) break;
            low_cnt++;
        end
        vectors++;
        if (low_cnt !== 4) begin miscompares++; $display("FAIL restart_reset_len got %0d want 4", low_cnt); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_result got done=%b pass=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        start_sat = 1'b1;
        @(posedge clk); #1;
        start_sat = 1'b0;
        cyc = 0;
        while (done_sat !== 1'b1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        vectors++;
        if (err_count_sat !== 4'd15 || pass_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_result got err=%0d pass=%b want 15 0", err_count_sat, pass_sat);
        end
        vectors++;
        if (observed_sat !== 4'd15 || busy_sat !== 1'b0 || macro_clk_sat !== 1'b0 || macro_n_reset_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_end got obs=%0d busy=%b mclk=%b mnr=%b want 15 0 0 1",
                     observed_sat, busy_sat, macro_clk_sat, macro_n_reset_sat);
        end
    endtask

    task automatic test_late_update();
        int lat;
        mode = 2;
        run_main(-1, lat);
        vectors++;
        if (err_count !== 8'd32 || pass !== 1'b0) begin
            miscompares++;
            $display("FAIL late_result got err=%0d pass=%b want 32 0", err_count, pass);
        end
        vectors++;
        if (observed !== 4'd15 || hist[0] !== 2) begin
            miscompares++;
            $display("FAIL late_observed got obs=%0d hist0=%0d want 15 2", observed, hist[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (err_count != 8'd0 && macro_clk === 1'b1) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (macro_clk !== 1'b1 || err_count === 8'd0) begin
            miscompares++;
            $display("FAIL midreset_setup got mclk=%b err=%0d want 1 nonzero", macro_clk, err_count);
        end
        #1 n_reset = 1'b0;
        #1;
        vectors++;
        if ({macro_clk, macro_n_reset, busy} !== 3'b000 || err_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_async got mclk=%b mnr=%b busy=%b err=%0d want 0 0 0 0",
                     macro_clk, macro_n_reset, busy, err_count);
        end
        #3 n_reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if ({macro_clk, macro_n_reset, busy, done} !== 4'b0000 || edges_seen !== 0) begin
            miscompares++;
            $display("FAIL midreset_idle got mclk=%b mnr=%b busy=%b done=%b edges=%0d want 0 0 0 0 0",
                     macro_clk, macro_n_reset, busy, done, edges_seen);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_start_mid_run();
        test_stuck();
        test_restart();
        test_saturate();
        test_late_update();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/psu_counter_checker.md
Name: psu_counter_checker

Overview:
- Digital self-test stage that drives the adjustable-PSU ripple counter macro and reads it back.
- Generates the macro's clock and active-low reset.
- Synchronises the macro's 4-bit count output into the core clock domain and compares it against an internal expected count after every macro clock edge.
- Reports error count and pass/fail so the macro can be characterised across supply voltages from the digital pins.

Parameters:
- HALF_PERIOD, 8: core clk cycles per macro_clk high phase and per low phase (≥2).
- SETTLE, 4: core cycles after a macro_clk rising edge before the synchroniser output is sampled. Constraint: SETTLE+2 < 2*HALF_PERIOD, checked by elaboration-time assertion.
- NUM_EDGES, 32: macro_clk rising edges per test run (1..65535).
- RESET_CYCLES, 4: core cycles macro_n_reset is held low at run start (≥1).
- ERR_W, 8: width of err_count.

Ports:
- clk  in  1  core clock.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request, sampled on clk.
- macro_count  in  4  count from macro via level shifter. Asynchronous to clk.
- macro_clk  out  1  clock to macro, registered.
- macro_n_reset  out  1  active-low reset to macro, registered.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ERR_W  saturating mismatch count for the current or last run.
- observed  out  4  most recent sampled (synchronised) count.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on n_reset. While n_reset=0:
  - state=IDLE;
  - macro_clk=0, macro_n_reset=0;
  - busy=0, done=0, pass=0, err_count=0, observed=0;
  - expected=0, edge counter=0, phase timer=0;
  - synchroniser flops=0.
- Synchroniser: 2-flop on each macro_count bit, no gray decoding. Compared value = 2nd flop output (2-cycle latency).
- FSM states: IDLE, RESET, CHECK0, RUN, DONE.
  - IDLE: macro_n_reset=0, macro_clk=0. On start=1: clear err_count, expected, edge counter and done, then go to RESET. busy=1 from the next cycle.
  - RESET: macro_n_reset=0 for exactly RESET_CYCLES cycles, then go to CHECK0 with macro_n_reset=1.
  - CHECK0: wait SETTLE+2 cycles. Latch the synchroniser output into observed and compare it to 0. Go to RUN with macro_clk rising on the first RUN cycle.
  - RUN: macro_clk alternates high HALF_PERIOD cycles, low HALF_PERIOD cycles.
    - On each rising edge (cycle t): expected <= expected+1 mod 16, so 15 wraps to 0. Edge counter increments.
    - At cycle t+SETTLE+2: latch observed and compare against expected.
    - After the compare following edge NUM_EDGES: finish the current low phase (macro_clk=0), then go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0), macro_n_reset=1, macro_clk=0. On start=1: behave as IDLE start and go to RESET.
- Mismatch handling: each mismatch increments err_count by 1, saturating at 2^ERR_W-1.
- start handling: start while busy=1 is ignored, with no effect on state or counters.
- Reset mid-run: asynchronous return to the reset values above. Macro is held in reset immediately, with no glitch on macro_clk beyond the forced 0.
- Run length: total compares per run = NUM_EDGES+1.
- Run latency from accepted start to done=1 = 1 + RESET_CYCLES + (SETTLE+2) + NUM_EDGES*2*HALF_PERIOD cycles, ±1 on the boundary. The bench must measure the exact value and lock it in the first regression.

Test Plan:
- Ideal macro model (count increments 1 clk after macro_clk rise, cleared by macro_n_reset), defaults, pulse start -> busy=1, then done=1, pass=1, err_count=0, observed=0 (32 mod 16), 32 macro_clk rising edges, macro_clk=0 at end.
- Model with count[2] stuck 0, defaults -> err_count=16, pass=0. Mismatches occur exactly at expected values 4..7 and 12..15, each occurring twice.
- ERR_W=4, model returns constant 15 -> 31 raw mismatches, err_count saturates at 15, pass=0.
- start asserted mid-RUN -> ignored, run finishes unchanged. Then start in DONE -> done=0, err_count=0 next cycle, macro_n_reset low for 4 cycles.
- n_reset low mid-RUN with macro_clk=1 -> same-cycle (asynchronous) macro_clk=0, macro_n_reset=0, busy=0, err_count=0. After release, FSM stays in IDLE until start.
- Model whose count updates SETTLE+3 cycles after each edge -> all 32 post-edge compares fail, CHECK0 passes, err_count=32, pass=0.
